// File: rtl/mips_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_mux_pkg
// Purpose  : Arbitration mode constants and select-width helper shared by
//            the result-selector blocks.
// Revision : 1.0
// ============================================================================
package mips_mux_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // An index bus is never narrower than one bit, even for a single channel.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational fixed-priority / rotating-priority arbiter that
//            returns a one-hot grant and the matching encoded index.
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              mode,
    output logic [NUM_IN-1:0] grant,
    output logic [SEL_W-1:0]  idx
);

    logic             w_found;
    logic [SEL_W-1:0] w_ch;

    // Search starts at ptr in rotating mode, at channel 0 otherwise.
    always_comb begin
        grant   = '0;
        idx     = '0;
        w_found = 1'b0;
        w_ch    = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (mode) begin
                w_ch = SEL_W'((int'(ptr) + k) % NUM_IN);
            end else begin
                w_ch = SEL_W'(k);
            end
            if (!w_found && req[w_ch]) begin
                grant[w_ch] = 1'b1;
                idx         = w_ch;
                w_found     = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : wb_arb_mux
// Purpose  : N-input registered result selector with valid/ready handshakes,
//            arbitrated or force-selected, feeding the register-file write port.
// Revision : 1.0
// ============================================================================
module wb_arb_mux
    import mips_mux_pkg::*;
#(
    parameter int  WIDTH  = 32,
    parameter int  NUM_IN = 4,
    parameter int  MODE   = ARB_RR,
    localparam int SEL_W  = sel_width(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN-1:0]       in_valid,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic                    force_en,
    input  logic [SEL_W-1:0]        force_sel,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    input  logic                    out_ready
);

    localparam bit c_rr_mode = (MODE == ARB_RR);

    logic [NUM_IN-1:0] w_force_req;
    logic [NUM_IN-1:0] w_req;
    logic [NUM_IN-1:0] w_grant;
    logic [SEL_W-1:0]  w_idx;
    logic [SEL_W-1:0]  w_ptr_next;
    logic              w_load;
    logic              w_xfer;
    logic [WIDTH-1:0]  w_sel_data;

    logic              r_out_valid;
    logic [WIDTH-1:0]  r_out_data;
    logic [SEL_W-1:0]  r_out_sel;
    logic [SEL_W-1:0]  r_ptr;

    // An out-of-range force_sel matches no channel, so nothing is requested.
    generate
        for (genvar i = 0; i < NUM_IN; i++) begin : g_force
            assign w_force_req[i] = in_valid[i] && (force_sel == SEL_W'(i));
        end
    endgenerate

    assign w_req = force_en ? w_force_req : in_valid;

    rr_arbiter #(
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_arb (
        .req   (w_req),
        .ptr   (r_ptr),
        .mode  (c_rr_mode),
        .grant (w_grant),
        .idx   (w_idx)
    );

    assign w_load   = !r_out_valid || out_ready;
    assign in_ready = w_grant & {NUM_IN{w_load && rst_n}};
    assign w_xfer   = |in_ready;

    // Grant is one-hot, so an OR of masked channels is a plain mux.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_grant[i]) begin
                w_sel_data = w_sel_data | in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_ptr_next = (w_idx == SEL_W'(NUM_IN - 1)) ? '0 : w_idx + SEL_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_ptr       <= '0;
        end else begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_sel   <= w_idx;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_xfer && !force_en && c_rr_mode) begin
                r_ptr <= w_ptr_next;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule
`default_nettype wire

// File: tb/tb_wb_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arb_mux
// Purpose  : Directed scoreboard bench for wb_arb_mux, round-robin and
//            fixed-priority instances driven from shared stimulus.
// Revision : 1.0
// ============================================================================
module tb_wb_arb_mux;

    localparam int WIDTH  = 32;
    localparam int NUM_IN = 4;
    localparam int SEL_W  = 2;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic [SEL_W-1:0] s;
    } exp_t;

    logic                    clk;
    logic                    rst_n;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic                    force_en;
    logic [SEL_W-1:0]        force_sel;
    logic                    out_ready;

    logic [NUM_IN-1:0]       rr_in_ready, fp_in_ready;
    logic                    rr_out_valid, fp_out_valid;
    logic [WIDTH-1:0]        rr_out_data, fp_out_data;
    logic [SEL_W-1:0]        rr_out_sel, fp_out_sel;

    exp_t q_rr[$];
    exp_t q_fp[$];
    exp_t cur_rr, cur_fp;
    logic vld_rr, vld_fp;

    int checks = 0;
    int errors = 0;

    wb_arb_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .MODE(1)) dut_rr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rr_in_ready), .force_en(force_en), .force_sel(force_sel),
        .out_valid(rr_out_valid), .out_data(rr_out_data), .out_sel(rr_out_sel),
        .out_ready(out_ready)
    );

    wb_arb_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .MODE(0)) dut_fp (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(fp_in_ready), .force_en(force_en), .force_sel(force_sel),
        .out_valid(fp_out_valid), .out_data(fp_out_data), .out_sel(fp_out_sel),
        .out_ready(out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [SEL_W-1:0] oh2idx(input logic [NUM_IN-1:0] oh);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_IN; i++) if (oh[i]) r = SEL_W'(i);
        return r;
    endfunction

    // One clock cycle, entered and left at a falling edge.
    task automatic step(input logic [NUM_IN-1:0] v, input logic ordy,
                        input logic fen, input logic [SEL_W-1:0] fsel,
                        input logic [WIDTH-1:0] d2,
                        input logic [NUM_IN-1:0] g_rr, input logic [NUM_IN-1:0] g_fp);
        exp_t e;
        in_valid  = v;
        out_ready = ordy;
        force_en  = fen;
        force_sel = fsel;
        for (int i = 0; i < NUM_IN; i++) in_data[i*WIDTH +: WIDTH] = $urandom;
        if (d2 != '0) in_data[2*WIDTH +: WIDTH] = d2;
        #1;
        chk("rr_in_ready", 64'(rr_in_ready), 64'(g_rr));
        chk("fp_in_ready", 64'(fp_in_ready), 64'(g_fp));
        if (g_rr != '0) begin
            e.s = oh2idx(g_rr);
            e.d = in_data[int'(e.s)*WIDTH +: WIDTH];
            q_rr.push_back(e);
        end
        if (g_fp != '0) begin
            e.s = oh2idx(g_fp);
            e.d = in_data[int'(e.s)*WIDTH +: WIDTH];
            q_fp.push_back(e);
        end
        @(posedge clk);
        #1;
        if (g_rr != '0) begin cur_rr = q_rr.pop_front(); vld_rr = 1'b1; end
        else if (ordy) vld_rr = 1'b0;
        if (g_fp != '0) begin cur_fp = q_fp.pop_front(); vld_fp = 1'b1; end
        else if (ordy) vld_fp = 1'b0;
        chk("rr_out_valid", 64'(rr_out_valid), 64'(vld_rr));
        chk("fp_out_valid", 64'(fp_out_valid), 64'(vld_fp));
        if (vld_rr) begin
            chk("rr_out_data", 64'(rr_out_data), 64'(cur_rr.d));
            chk("rr_out_sel", 64'(rr_out_sel), 64'(cur_rr.s));
        end
        if (vld_fp) begin
            chk("fp_out_data", 64'(fp_out_data), 64'(cur_fp.d));
            chk("fp_out_sel", 64'(fp_out_sel), 64'(cur_fp.s));
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        in_data   = '0;
        force_en  = 1'b0;
        force_sel = '0;
        out_ready = 1'b1;
        vld_rr    = 1'b0;
        vld_fp    = 1'b0;
        cur_rr    = '{d: '0, s: '0};
        cur_fp    = '{d: '0, s: '0};
        #2;
        chk("rst_rr_in_ready", 64'(rr_in_ready), 64'h0);
        chk("rst_fp_in_ready", 64'(fp_in_ready), 64'h0);
        chk("rst_rr_out_valid", 64'(rr_out_valid), 64'h0);
        chk("rst_rr_out_data", 64'(rr_out_data), 64'h0);
        chk("rst_rr_out_sel", 64'(rr_out_sel), 64'h0);
        repeat (2) @(negedge clk);
        chk("rst_hold_in_ready", 64'(rr_in_ready), 64'h0);
        chk("rst_hold_out_valid", 64'(fp_out_valid), 64'h0);
        rst_n = 1'b1;

        // Round-robin rotation 0,1,2,3,0 ; fixed priority always ch0
        step(4'b1111, 1'b1, 1'b0, 2'd0, '0, 4'b0001, 4'b0001);
        step(4'b1111, 1'b1, 1'b0, 2'd0, '0, 4'b0010, 4'b0001);
        step(4'b1111, 1'b1, 1'b0, 2'd0, '0, 4'b0100, 4'b0001);
        step(4'b1111, 1'b1, 1'b0, 2'd0, '0, 4'b1000, 4'b0001);
        step(4'b1111, 1'b1, 1'b0, 2'd0, '0, 4'b0001, 4'b0001);

        // ch1/ch3 requesting: fixed priority starves ch3, rr alternates
        step(4'b1010, 1'b1, 1'b0, 2'd0, '0, 4'b0010, 4'b0010);
        step(4'b1010, 1'b1, 1'b0, 2'd0, '0, 4'b1000, 4'b0010);
        step(4'b1010, 1'b1, 1'b0, 2'd0, '0, 4'b0010, 4'b0010);

        // Load 0xDEADBEEF from ch2, then stall three cycles
        step(4'b0100, 1'b1, 1'b0, 2'd0, 32'hDEADBEEF, 4'b0100, 4'b0100);
        for (int c = 0; c < 3; c++) begin
            step(4'b1111, 1'b0, 1'b0, 2'd0, '0, 4'b0000, 4'b0000);
            chk("stall_data", 64'(rr_out_data), 64'hDEADBEEF);
            chk("stall_sel", 64'(rr_out_sel), 64'd2);
        end
        step(4'b1111, 1'b1, 1'b0, 2'd0, '0, 4'b1000, 4'b0001);

        // Forced select of ch2 leaves the rr pointer at 0
        step(4'b1111, 1'b1, 1'b1, 2'd2, '0, 4'b0100, 4'b0100);
        step(4'b1111, 1'b1, 1'b1, 2'd2, '0, 4'b0100, 4'b0100);
        step(4'b1111, 1'b1, 1'b0, 2'd0, '0, 4'b0001, 4'b0001);
        step(4'b1011, 1'b1, 1'b1, 2'd2, '0, 4'b0000, 4'b0000);
        step(4'b1011, 1'b1, 1'b1, 2'd2, '0, 4'b0000, 4'b0000);

        // Back-to-back refill with no bubble
        step(4'b0001, 1'b1, 1'b0, 2'd0, '0, 4'b0001, 4'b0001);
        step(4'b0001, 1'b1, 1'b0, 2'd0, '0, 4'b0001, 4'b0001);

        // Asynchronous reset while holding a word
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("async_rst_valid", 64'(rr_out_valid), 64'h0);
        chk("async_rst_data", 64'(rr_out_data), 64'h0);
        chk("async_rst_sel", 64'(fp_out_sel), 64'h0);
        chk("async_rst_ready", 64'(rr_in_ready), 64'h0);
        vld_rr = 1'b0;
        vld_fp = 1'b0;
        q_rr.delete();
        q_fp.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b1111, 1'b1, 1'b0, 2'd0, '0, 4'b0001, 4'b0001);
        step(4'b1111, 1'b1, 1'b0, 2'd0, '0, 4'b0010, 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_arb_mux.md
# wb_arb_mux

Parametrised N-input registered result selector with valid/ready handshakes, the next generation of the datapath 2:1 and 3:1 muxes. It sits in front of the register-file write port. It merges results from the ALU, load unit, mult/div unit and spares into one registered output stream. Selection is by fixed-priority or round-robin arbitration, or by an explicit forced select that reproduces classic mux behaviour.

## Interface
- `WIDTH`, 32, data width of each input and of the output
- `NUM_IN`, 4, number of input channels (1..16)
- `MODE`, 1, arbitration mode: 0 = fixed priority (channel 0 highest), 1 = round-robin
- `SEL_W`, derived: max(1, clog2(NUM_IN)); not user-set
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_valid`  in  NUM_IN  per-channel request
- `in_data`  in  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- `in_ready`  out  NUM_IN  per-channel accept, one-hot or zero
- `force_en`  in  1  bypass arbitration; only `force_sel` may be granted
- `force_sel`  in  SEL_W  forced channel index
- `out_valid`  out  1  output register holds a result
- `out_data`  out  WIDTH  registered selected data
- `out_sel`  out  SEL_W  index of the channel that produced `out_data`
- `out_ready`  in  1  downstream accept

## Operation
- Transfer on input i occurs when `in_valid[i] && in_ready[i]` at a rising edge; output transfer when `out_valid && out_ready`.
- `load` = `!out_valid || out_ready`; the output register accepts a new word only when `load` is 1.
- Grant (combinational, from current inputs and pointer):
  - `force_en`=1: grant `force_sel` iff `in_valid[force_sel]`; `force_sel` ≥ NUM_IN grants nothing.
  - MODE 0: lowest-index valid channel.
  - MODE 1: first valid channel searching ptr, ptr+1, … wrapping mod NUM_IN.
- `in_ready[i]` = `grant[i] && load`; never more than one bit set.
- On input transfer: `out_data`/`out_sel` take the granted channel's data and index, and `out_valid` is set to 1.
- On output transfer with no input transfer, `out_valid` is cleared to 0. `out_data`/`out_sel` hold their last values.
- Round-robin pointer `ptr` (SEL_W bits) updates only on an input transfer with `force_en`=0 and MODE 1:
  - ptr ← granted+1, wrapping to 0 after NUM_IN-1.
  - In all other cycles ptr is held, including forced cycles, stalls and cycles with no valid input.
- Stall (`out_valid && !out_ready`): all `in_ready` are 0, and `out_data`/`out_sel`/`out_valid` are stable.
- Simultaneous output drain and new input transfer in one edge: the new word replaces the old one and `out_valid` stays 1. This gives a throughput of one word per cycle.
- NUM_IN=1: ptr is constant 0 and the block degenerates to a one-entry pipeline register.

## Timing
- Reset (async assert, sync release on `clk`): `out_valid`=0, `out_data`=0, `out_sel`=0, ptr=0; `in_ready` is 0 while `rst_n`=0.
- Reset asserted mid-transfer discards the held word; no partial state survives.
- Latency: input accepted at edge k appears on `out_data` immediately after edge k (1 cycle).
- Sustained throughput: 1 word/cycle while `out_ready`=1.
- `in_ready` depends combinationally on `in_valid`, `force_en`, `force_sel`, `out_valid` and `out_ready`. No output depends combinationally on `in_data`.

## Structure
- Shared package `mips_mux_pkg`:
  - mode constants `ARB_FIXED`=0 and `ARB_RR`=1
  - a `sel_width(n)` function returning max(1, clog2(n))
- Sub-module `rr_arbiter` takes (`req`, `ptr`, `mode`) and returns a one-hot `grant` plus the encoded index. It is purely combinational.
- The top level holds the output register and ptr.

## Test plan
- Reset with `in_valid`=4'b1111 held: `out_valid`=0 and `in_ready`=0 during reset. On release, MODE 1 grants ch0 first, then ch1, ch2, ch3, ch0 on successive cycles with `out_ready`=1. `out_sel` follows 0,1,2,3,0.
- MODE 0, `in_valid`=4'b1010, `out_ready`=1: ch1 granted every cycle and ch3 starves. `out_data` equals ch1 data one cycle later.
- Stall: `out_ready`=0 for 3 cycles after a load of 0xDEADBEEF from ch2:
  - `out_data`=0xDEADBEEF, `out_sel`=2 and `in_ready`=0 throughout
  - ptr unchanged
  - after `out_ready` returns high, the next grant is ch3.
- Forced select: `force_en`=1 and `force_sel`=2 with all channels valid give ch2 only, and ptr is unchanged. With `force_sel`=2 and `in_valid[2]`=0 there is no grant and `out_valid` drops after a drain.
- Back-to-back drain and refill: with `out_valid`=1, `out_ready`=1 and ch0 valid, `out_valid` stays 1 and `out_data` updates in the same edge with no bubble.
- Reset asserted while `out_valid`=1: the outputs clear immediately (asynchronously), before the next clock edge.
